// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and its sibling transmitter.
// The default bit period lives here so both ends agree on the baud rate.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned UART_DATA_BITS    = 9;
    localparam int unsigned UART_CLKS_PER_BIT = 16;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a short sample history
// used for edge detection and a three-sample majority vote.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic rx,
    output logic rs,
    output logic prev,
    output logic vote
);

    logic       meta;
    logic [1:0] hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b1;
            rs   <= 1'b1;
            hist <= 2'b11;
        end else begin
            meta <= rx;
            rs   <= meta;
            hist <= {hist[0], rs};
        end
    end

    // Vote over the current and two previous synchronized samples.
    assign vote = majority3({hist, rs});
    assign prev = hist[0];

endmodule

// File: rtl/uart_rx9_receiver.sv
// 9-bit UART receiver: start bit, DATA_BITS LSB-first, one stop bit, no parity.
// Good words are presented with a one-cycle done strobe; bad stop bits set framing_error.
module uart_rx9_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 framing_error
);

    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW  = $clog2(DATA_BITS + 1);
    localparam int unsigned MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] SAMPLE_AT = CW'(MID + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    logic rs;
    logic prev;
    logic vote;

    uart_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .rs    (rs),
        .prev  (prev),
        .vote  (vote)
    );

    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           warm;

    logic sample;
    assign sample = (cnt == SAMPLE_AT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            warm          <= '0;
            data          <= '0;
            done          <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            // The synchronizer's reset value is not a real line sample; wait until
            // the history holds genuine samples so a line low from reset is ignored.
            if (warm != 2'b11) warm <= warm + 2'd1;

            case (state)
                IDLE: begin
                    if (warm == 2'b11 && prev && !rs) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (vote == START_BIT) begin
                            framing_error <= 1'b0;
                            idx           <= '0;
                            state         <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (idx == LAST_IDX) state <= STOP;
                        else                 idx   <= idx + 1'b1;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a start bit right after it is caught.
                    if (sample) begin
                        if (vote == STOP_BIT) begin
                            data  <= shreg;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx9_receiver.sv
// Scoreboard bench for uart_rx9_receiver: frames are generated as timed rx waveforms,
// expected words are queued at the start bit and matched when done pulses.
module tb_uart_rx9_receiver;

    localparam int PER = 100;
    localparam int BT  = 16 * PER;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [8:0] data;
    logic       done;
    logic       framing_error;

    always #(PER / 2) clock = ~clock;

    uart_rx9_receiver #(
        .CLKS_PER_BIT (16),
        .DATA_BITS    (9)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .done          (done),
        .framing_error (framing_error)
    );

    typedef struct {
        logic [8:0] d;
        longint     fall;
        bit         lat;
    } exp_t;

    exp_t       sb[$];
    int         checks     = 0;
    int         failures   = 0;
    int         done_count = 0;
    longint     cyc        = 0;
    logic [8:0] model_data = '0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done and watches data between strobes.
    logic       prev_done = 1'b0;
    logic [8:0] mon_data  = '0;

    always @(negedge clock) begin
        exp_t   e;
        longint lat_c;
        if (reset) begin
            prev_done = 1'b0;
            mon_data  = '0;
        end else begin
            if (done) begin
                done_count++;
                check("done_spacing", {31'd0, prev_done}, 32'd0);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done with data %0h, expected none", data);
                end else begin
                    e = sb.pop_front();
                    check("data", {23'd0, data}, {23'd0, e.d});
                    check("fe_at_done", {31'd0, framing_error}, 32'd0);
                    if (e.lat) begin
                        lat_c = cyc - e.fall;
                        checks++;
                        if (lat_c < 171 || lat_c > 173) begin
                            failures++;
                            $display("FAIL latency: got %0d cycles, expected 171..173", lat_c);
                        end
                    end
                    mon_data = e.d;
                end
            end else begin
                check("data_stable", {23'd0, data}, {23'd0, mon_data});
            end
            prev_done = done;
        end
    end

    // Drives one frame starting now; caller aligns to a falling clock edge when needed.
    task automatic send_frame(input logic [8:0] w, input bit stop_ok, input int bt,
                              input bit noise, input bit lat);
        exp_t e;
        if (stop_ok) begin
            e.d  = w;
            e.fall = cyc;
            e.lat  = lat;
            sb.push_back(e);
            model_data = w;
        end
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 9; i++) begin
            rx = w[i];
            if (noise) begin
                #(bt / 2);
                rx = ~w[i];
                #(PER);
                rx = w[i];
                #(bt - bt / 2 - PER);
            end else begin
                #(bt);
            end
        end
        rx = stop_ok;
        #(bt);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #(PER * 80000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         snap;
        int         gap;
        bit         ok;
        logic [8:0] w;

        // Reset values.
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_data", {23'd0, data}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_fe", {31'd0, framing_error}, 32'd0);

        // Line held low across reset release must not start a frame.
        reset = 1'b1;
        rx    = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        idle(200);
        check("low_from_reset_no_done", done_count, 0);

        // Nominal frame.
        send_frame(9'h1A5, 1'b1, BT, 1'b0, 1'b1);
        idle(20);
        drain();
        check("good_frame_data", {23'd0, data}, 32'h1A5);
        check("good_frame_count", done_count, 1);

        // Back-to-back frames with no idle gap.
        send_frame(9'h000, 1'b1, BT, 1'b0, 1'b1);
        send_frame(9'h1FF, 1'b1, BT, 1'b0, 1'b1);
        idle(20);
        drain();
        check("b2b_count", done_count, 3);

        // Short glitch.
        snap = done_count;
        rx = 1'b0;
        repeat (3) @(negedge clock);
        idle(60);
        check("glitch_no_done", done_count, snap);
        check("glitch_data", {23'd0, data}, {23'd0, model_data});

        // Bad stop bit followed by a long break.
        send_frame(9'h0F0, 1'b0, BT, 1'b0, 1'b0);
        repeat (40 * 16) @(negedge clock);
        check("break_fe", {31'd0, framing_error}, 32'd1);
        check("break_no_done", done_count, snap);
        check("break_data", {23'd0, data}, {23'd0, model_data});
        idle(40);
        check("fe_sticky", {31'd0, framing_error}, 32'd1);
        send_frame(9'h055, 1'b1, BT, 1'b0, 1'b1);
        idle(20);
        drain();
        check("recover_fe", {31'd0, framing_error}, 32'd0);
        check("recover_data", {23'd0, data}, 32'h055);

        // One-cycle inverted pulses inside each data bit.
        send_frame(9'h12C, 1'b1, BT, 1'b1, 1'b1);
        idle(20);
        drain();
        check("noise_data", {23'd0, data}, 32'h12C);

        // Baud offsets of +3% and -3%.
        w = 9'($urandom_range(0, 511));
        send_frame(w, 1'b1, BT * 103 / 100, 1'b0, 1'b0);
        idle(20);
        drain();
        check("baud_slow_data", {23'd0, data}, {23'd0, w});
        w = 9'($urandom_range(0, 511));
        send_frame(w, 1'b1, BT * 97 / 100, 1'b0, 1'b0);
        idle(20);
        drain();
        check("baud_fast_data", {23'd0, data}, {23'd0, w});

        // Reset during data bit 4.
        snap = done_count;
        w = 9'h1AA;
        rx = 1'b0;
        #(BT);
        for (int i = 0; i < 4; i++) begin
            rx = w[i];
            #(BT);
        end
        rx = w[4];
        #(BT / 2);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clock);
        model_data = '0;
        check("midreset_data", {23'd0, data}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_fe", {31'd0, framing_error}, 32'd0);
        reset = 1'b0;
        idle(30);
        check("midreset_no_done", done_count, snap);
        send_frame(9'h033, 1'b1, BT, 1'b0, 1'b1);
        idle(20);
        drain();
        check("after_reset_data", {23'd0, data}, 32'h033);

        // Randomized frames, gaps and occasional stop-bit errors.
        for (int n = 0; n < 16; n++) begin
            w   = 9'($urandom_range(0, 511));
            ok  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 30);
            send_frame(w, ok, BT, 1'b0, 1'b1);
            if (!ok) begin
                check("rand_fe", {31'd0, framing_error}, 32'd1);
                if (gap < 3) gap = 3;
            end
            if (gap > 0) idle(gap);
        end
        idle(20);
        drain();
        check("rand_final_data", {23'd0, data}, {23'd0, model_data});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
